// File: rtl/ram64x18_pkg.sv
// Shared constants, width-code enum and address/width helpers for the 64x18 micro-SRAM model.
// Optional build macro used by this block: RAM64X18_RESET_CLEAR_EN (reset also clears the array).
package ram64x18_pkg;

    localparam int MEM_BITS = 1152;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 18;
    localparam int OFF_W    = 11;

    typedef enum logic [2:0] {
        W1  = 3'b000,
        W2  = 3'b001,
        W4  = 3'b010,
        W9  = 3'b011,
        W18 = 3'b100
    } width_e;

    // Codes 101..111 alias the widest mode.
    function automatic width_e decode_width(input logic [2:0] code);
        case (code)
            3'b000:  decode_width = W1;
            3'b001:  decode_width = W2;
            3'b010:  decode_width = W4;
            3'b011:  decode_width = W9;
            default: decode_width = W18;
        endcase
    endfunction

    function automatic logic [4:0] width_bits(input logic [2:0] code);
        case (decode_width(code))
            W1:      width_bits = 5'd1;
            W2:      width_bits = 5'd2;
            W4:      width_bits = 5'd4;
            W9:      width_bits = 5'd9;
            default: width_bits = 5'd18;
        endcase
    endfunction

    function automatic logic [2:0] addr_shift(input logic [2:0] code);
        case (decode_width(code))
            W1:      addr_shift = 3'd0;
            W2:      addr_shift = 3'd1;
            W4:      addr_shift = 3'd2;
            W9:      addr_shift = 3'd3;
            default: addr_shift = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] width_mask(input logic [2:0] code);
        logic [DATA_W:0] one_past;
        one_past   = (DATA_W+1)'(1) << width_bits(code);
        width_mask = DATA_W'(one_past - (DATA_W+1)'(1));
    endfunction

    // Largest reachable offset is 1143 (128x9) or 1134 (64x18), so 11 bits suffice.
    function automatic logic [OFF_W-1:0] bit_offset(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0]        code);
        logic [ADDR_W-1:0] idx;
        idx        = addr >> addr_shift(code);
        bit_offset = OFF_W'(idx) * OFF_W'(width_bits(code));
    endfunction

endpackage

// File: rtl/ram64x18_rd_port.sv
// One read port of the 64x18 micro-SRAM: optional address register, array mux,
// width masking and optional output register.
module ram64x18_rd_port
    import ram64x18_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [1:0]          blk_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [2:0]          width_i,
    input  logic                addr_en_i,
    input  logic                addr_lat_i,
    input  logic                dout_en_i,
    input  logic                dout_lat_i,
    input  logic [MEM_BITS-1:0] mem_i,
    output logic [DATA_W-1:0]   dout_o
);

    logic [ADDR_W-1:0]          addr_q;
    logic [ADDR_W-1:0]          addr_d;
    logic [ADDR_W-1:0]          eff_addr;
    logic [DATA_W-1:0]          dout_q;
    logic [DATA_W-1:0]          dout_d;
    logic [DATA_W-1:0]          rd_data;
    logic [MEM_BITS+DATA_W-1:0] mem_pad;
    logic [OFF_W-1:0]           rd_off;
    logic                       sel;

    assign sel      = en_i && (blk_i == 2'b11);
    assign eff_addr = addr_lat_i ? addr_i : addr_q;

    // Zero padding keeps an 18-bit slice in range even at the last 128x9 word.
    assign mem_pad  = {{DATA_W{1'b0}}, mem_i};
    assign rd_off   = bit_offset(eff_addr, width_i);
    assign rd_data  = mem_pad[rd_off +: DATA_W] & width_mask(width_i);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        addr_d = addr_q;
        dout_d = dout_q;
        if (addr_en_i) begin
            addr_d = addr_i;
        end
        if (dout_en_i && sel) begin
            dout_d = rd_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            addr_q <= addr_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_lat_i ? (sel ? rd_data : '0) : dout_q;

endmodule

// File: rtl/ram64x18.sv
// 64x18 micro-SRAM behavioural model: one write port, two read ports, one clock.
// Build macro RAM64X18_RESET_CLEAR_EN makes reset clear the array and drop a coincident write.
module ram64x18
    import ram64x18_pkg::*;
(
    input  logic                clock,
    input  logic                reset,

    input  logic                A_EN,
    input  logic [1:0]          A_BLK,
    input  logic [ADDR_W-1:0]   A_ADDR,
    input  logic [2:0]          A_WIDTH,
    input  logic                A_ADDR_EN,
    input  logic                A_ADDR_LAT,
    input  logic                A_DOUT_EN,
    input  logic                A_DOUT_LAT,
    output logic [DATA_W-1:0]   A_DOUT,

    input  logic                B_EN,
    input  logic [1:0]          B_BLK,
    input  logic [ADDR_W-1:0]   B_ADDR,
    input  logic [2:0]          B_WIDTH,
    input  logic                B_ADDR_EN,
    input  logic                B_ADDR_LAT,
    input  logic                B_DOUT_EN,
    input  logic                B_DOUT_LAT,
    output logic [DATA_W-1:0]   B_DOUT,

    input  logic                C_EN,
    input  logic [1:0]          C_BLK,
    input  logic                C_WEN,
    input  logic [ADDR_W-1:0]   C_ADDR,
    input  logic [DATA_W-1:0]   C_DIN,
    input  logic [2:0]          C_WIDTH,

    output logic                BUSY
);

    logic [MEM_BITS-1:0] mem_q;
    logic [MEM_BITS-1:0] mem_d;
    logic [MEM_BITS-1:0] wr_mask;
    logic [MEM_BITS-1:0] wr_data;
    logic [OFF_W-1:0]    wr_off;
    logic                wr_en;

    assign wr_en  = C_EN && C_WEN && (C_BLK == 2'b11);
    assign wr_off = bit_offset(C_ADDR, C_WIDTH);

    // Only the low width bits of C_DIN land in the array; every other bit is preserved.
    always_comb begin
        wr_mask = MEM_BITS'(width_mask(C_WIDTH)) << wr_off;
        wr_data = MEM_BITS'(C_DIN & width_mask(C_WIDTH)) << wr_off;
        mem_d   = mem_q;
        if (wr_en) begin
            mem_d = (mem_q & ~wr_mask) | (wr_data & wr_mask);
        end
    end

`ifdef RAM64X18_RESET_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
`else
    // NOTE: the array is deliberately left out of reset; its contents survive it.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
`endif

    ram64x18_rd_port u_port_a (
        .clk_i      (clock),
        .rst_i      (reset),
        .en_i       (A_EN),
        .blk_i      (A_BLK),
        .addr_i     (A_ADDR),
        .width_i    (A_WIDTH),
        .addr_en_i  (A_ADDR_EN),
        .addr_lat_i (A_ADDR_LAT),
        .dout_en_i  (A_DOUT_EN),
        .dout_lat_i (A_DOUT_LAT),
        .mem_i      (mem_q),
        .dout_o     (A_DOUT)
    );

    ram64x18_rd_port u_port_b (
        .clk_i      (clock),
        .rst_i      (reset),
        .en_i       (B_EN),
        .blk_i      (B_BLK),
        .addr_i     (B_ADDR),
        .width_i    (B_WIDTH),
        .addr_en_i  (B_ADDR_EN),
        .addr_lat_i (B_ADDR_LAT),
        .dout_en_i  (B_DOUT_EN),
        .dout_lat_i (B_DOUT_LAT),
        .mem_i      (mem_q),
        .dout_o     (B_DOUT)
    );

    assign BUSY = 1'b0;

endmodule

// File: tb/tb_ram64x18.sv
// Directed bench for ram64x18: hand-computed vectors covering latency modes, aspect ratios,
// read-during-write, block selects and reset (array clear follows RAM64X18_RESET_CLEAR_EN).
module tb_ram64x18;

`ifdef RAM64X18_RESET_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        A_EN, A_ADDR_EN, A_ADDR_LAT, A_DOUT_EN, A_DOUT_LAT;
    logic [1:0]  A_BLK;
    logic [9:0]  A_ADDR;
    logic [2:0]  A_WIDTH;
    logic [17:0] A_DOUT;
    logic        B_EN, B_ADDR_EN, B_ADDR_LAT, B_DOUT_EN, B_DOUT_LAT;
    logic [1:0]  B_BLK;
    logic [9:0]  B_ADDR;
    logic [2:0]  B_WIDTH;
    logic [17:0] B_DOUT;
    logic        C_EN, C_WEN;
    logic [1:0]  C_BLK;
    logic [9:0]  C_ADDR;
    logic [17:0] C_DIN;
    logic [2:0]  C_WIDTH;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    ram64x18 dut (
        .clock      (clock),
        .reset      (reset),
        .A_EN       (A_EN),
        .A_BLK      (A_BLK),
        .A_ADDR     (A_ADDR),
        .A_WIDTH    (A_WIDTH),
        .A_ADDR_EN  (A_ADDR_EN),
        .A_ADDR_LAT (A_ADDR_LAT),
        .A_DOUT_EN  (A_DOUT_EN),
        .A_DOUT_LAT (A_DOUT_LAT),
        .A_DOUT     (A_DOUT),
        .B_EN       (B_EN),
        .B_BLK      (B_BLK),
        .B_ADDR     (B_ADDR),
        .B_WIDTH    (B_WIDTH),
        .B_ADDR_EN  (B_ADDR_EN),
        .B_ADDR_LAT (B_ADDR_LAT),
        .B_DOUT_EN  (B_DOUT_EN),
        .B_DOUT_LAT (B_DOUT_LAT),
        .B_DOUT     (B_DOUT),
        .C_EN       (C_EN),
        .C_BLK      (C_BLK),
        .C_WEN      (C_WEN),
        .C_ADDR     (C_ADDR),
        .C_DIN      (C_DIN),
        .C_WIDTH    (C_WIDTH),
        .BUSY       (BUSY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [9:0] addr, input logic [2:0] width, input logic [17:0] din);
        C_EN    = 1'b1;
        C_WEN   = 1'b1;
        C_BLK   = 2'b11;
        C_ADDR  = addr;
        C_WIDTH = width;
        C_DIN   = din;
        tick();
        C_WEN   = 1'b0;
    endtask

    function automatic logic [17:0] pat(input int i);
        pat = 18'(i * 4099 + 341);
    endfunction

    initial begin
        reset = 1'b1;
        A_EN = 1'b1; A_BLK = 2'b11; A_ADDR = '0; A_WIDTH = 3'b011;
        A_ADDR_EN = 1'b0; A_ADDR_LAT = 1'b0; A_DOUT_EN = 1'b0; A_DOUT_LAT = 1'b0;
        B_EN = 1'b1; B_BLK = 2'b11; B_ADDR = '0; B_WIDTH = 3'b011;
        B_ADDR_EN = 1'b0; B_ADDR_LAT = 1'b0; B_DOUT_EN = 1'b0; B_DOUT_LAT = 1'b0;
        C_EN = 1'b0; C_WEN = 1'b0; C_BLK = 2'b11; C_ADDR = '0; C_DIN = '0; C_WIDTH = 3'b000;
        tick();
        tick();
        reset = 1'b0;
        check("reset_a_dout", A_DOUT, 18'h0);
        check("reset_b_dout", B_DOUT, 18'h0);
        check("reset_busy", {17'h0, BUSY}, 18'h0);

        // 128x9 writes, then registered address / transparent output: 1-cycle latency
        write(10'd40, 3'b011, 18'h000A5);
        write(10'd48, 3'b011, 18'h00012);
        A_ADDR = 10'd40; A_ADDR_EN = 1'b1; A_DOUT_LAT = 1'b1;
        tick();
        check("a_lat1", A_DOUT, 18'h000A5);
        B_ADDR_LAT = 1'b1; B_DOUT_LAT = 1'b1; B_ADDR = 10'd48;
        #1;
        check("b_lat0", B_DOUT, 18'h00012);

        // registered address and output: 2-cycle latency, then reset clears the output
        A_DOUT_LAT = 1'b0; A_DOUT_EN = 1'b1; A_ADDR = 10'd48;
        tick();
        tick();
        A_ADDR = 10'd40;
        tick();
        check("a_lat2_first_edge", A_DOUT, 18'h00012);
        tick();
        check("a_lat2", A_DOUT, 18'h000A5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("a_reset_clear", A_DOUT, 18'h0);
        tick();
        tick();
        check("a_reread", A_DOUT, CLR ? 18'h0 : 18'h000A5);

        // 64x18 write of all ones viewed through narrower aspects
        write(10'd48, 3'b100, 18'h3FFFF);
        B_WIDTH = 3'b011; B_ADDR = 10'd48; #1;
        check("x9_word6", B_DOUT, 18'h001FF);
        B_ADDR = 10'd56; #1;
        check("x9_word7", B_DOUT, 18'h001FF);
        B_WIDTH = 3'b000; B_ADDR = 10'd54; #1;
        check("x1_bit54", B_DOUT, 18'h00001);
        B_ADDR = 10'd53; #1;
        check("x1_bit53", B_DOUT, 18'h00000);
        B_WIDTH = 3'b111; B_ADDR = 10'd48; #1;
        check("code7_as_x18", B_DOUT, 18'h3FFFF);
        B_WIDTH = 3'b011; B_ADDR = 10'd40; #1;
        check("x9_neighbour", B_DOUT, CLR ? 18'h0 : 18'h000A5);

        // read-during-write on word 7 (128x9)
        write(10'd56, 3'b011, 18'h00011);
        A_ADDR_LAT = 1'b1; A_ADDR = 10'd56; A_DOUT_LAT = 1'b0; A_DOUT_EN = 1'b1; A_WIDTH = 3'b011;
        B_ADDR_LAT = 1'b0; B_DOUT_LAT = 1'b1; B_ADDR = 10'd56; B_ADDR_EN = 1'b1;
        write(10'd56, 3'b011, 18'h00022);
        check("rdw_dout_old", A_DOUT, 18'h00011);
        check("rdw_addr_new", B_DOUT, 18'h00022);
        tick();
        check("rdw_next_capture", A_DOUT, 18'h00022);

        // registered output holds while deselected or not enabled
        A_EN = 1'b0;
        write(10'd56, 3'b011, 18'h00033);
        tick();
        check("hold_en_low", A_DOUT, 18'h00022);
        A_EN = 1'b1; A_DOUT_EN = 1'b0;
        tick();
        check("hold_dout_en_low", A_DOUT, 18'h00022);
        A_DOUT_EN = 1'b1;
        tick();
        check("capture_after_hold", A_DOUT, 18'h00033);

        // write blocked by C_BLK and by C_EN; transparent output zero when deselected
        C_EN = 1'b1; C_WEN = 1'b1; C_BLK = 2'b01; C_ADDR = 10'd56; C_WIDTH = 3'b011; C_DIN = 18'h001AA;
        tick();
        C_BLK = 2'b11; C_EN = 1'b0;
        tick();
        C_WEN = 1'b0; C_EN = 1'b1;
        B_ADDR_LAT = 1'b1; B_ADDR = 10'd56; #1;
        check("c_blk_no_write", B_DOUT, 18'h00033);
        A_DOUT_LAT = 1'b1; A_BLK = 2'b10; #1;
        check("a_blk_zero", A_DOUT, 18'h0);
        A_BLK = 2'b11; #1;
        check("a_blk_selected", A_DOUT, 18'h00033);
        A_EN = 1'b0; #1;
        check("a_en_zero", A_DOUT, 18'h0);
        A_EN = 1'b1;

        // narrow writes store only their low bits
        write(10'd55, 3'b000, 18'h3FFFE);
        write(10'd60, 3'b010, 18'h3FFFA);
        B_ADDR = 10'd48; #1;
        check("narrow_word6", B_DOUT, 18'h000BD);
        B_ADDR = 10'd56; #1;
        check("narrow_word7", B_DOUT, 18'h00033);

        // write coincident with reset
        reset = 1'b1;
        write(10'd64, 3'b011, 18'h00055);
        reset = 1'b0;
        B_ADDR = 10'd64; #1;
        check("write_during_reset", B_DOUT, CLR ? 18'h0 : 18'h00055);
        check("busy_idle", {17'h0, BUSY}, 18'h0);

        // fill all 64 words, pulse reset, read back
        for (int i = 0; i < 64; i++) begin
            write(10'(i << 4), 3'b100, pat(i));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        B_WIDTH = 3'b100;
        for (int i = 0; i < 64; i++) begin
            B_ADDR = 10'(i << 4);
            #1;
            check($sformatf("fill_word%0d", i), B_DOUT, CLR ? 18'h0 : pat(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
